stream_bfm_v2: RTL and testbench
================================

Name: stream_bfm_v2

Overview:
- Parametrised, synthesizable stream BFM: successor to the fixed 255-bit single-pass Poseidon harness.
- Buffers host-written beats in a TX FIFO and drives them onto a valid/ready/last stream into the DUT.
- Captures the DUT output stream into an RX FIFO.
- Programmable valid/ready throttling modes, frame counters and a stall watchdog, so cocotb tests can exercise back-pressure without per-cycle Python poking.

Parameters:
- DATA_W, 255, payload width of both streams
- DEPTH, 16, entries per FIFO; power of 2, at least 2
- CNT_W, 16, width of frame counters
- TIMEOUT, 1024, watchdog threshold in cycles; at least 1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- tx_wr_en  in  1  host pushes a beat into TX FIFO
- tx_wr_data  in  DATA_W  beat payload
- tx_wr_last  in  1  beat ends a frame
- tx_full  out  1  TX FIFO full
- tx_level  out  clog2(DEPTH)+1  TX occupancy
- m_valid  out  1  stream to DUT input: valid
- m_ready  in  1  DUT input ready
- m_last  out  1  DUT input last
- m_payload  out  DATA_W  DUT input payload
- s_valid  in  1  DUT output valid
- s_ready  out  1  DUT output ready
- s_last  in  1  DUT output last
- s_payload  in  DATA_W  DUT output payload
- rx_rd_en  in  1  host pops RX head
- rx_rd_data  out  DATA_W  RX head payload (first-word-fall-through)
- rx_rd_last  out  1  RX head last flag
- rx_empty  out  1  RX FIFO empty
- rx_level  out  clog2(DEPTH)+1  RX occupancy
- cfg_valid_mode  in  2  0 always, 1 alternate, 2 random, 3 stall
- cfg_ready_mode  in  2  same encoding, applied to s_ready
- tx_frames  out  CNT_W  frames fully accepted by DUT
- rx_frames  out  CNT_W  frames fully captured
- tx_drop  out  1  sticky: push attempted while full
- timeout_flag  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, active-high): FIFOs emptied, LFSR seeded 16'hACE1, all counters and sticky flags 0.
  - Outputs while reset is high and in the first cycle after: m_valid=0, s_ready=0, tx_full=0, rx_empty=1, levels 0.
  - Reset mid-frame discards all buffered beats; no partial frame is resumed.
- TX push: tx_wr_en && !tx_full writes the beat. tx_wr_en while tx_full drops the beat and sets tx_drop.
- TX output latency: beat written at edge N can present m_valid at cycle N+1 (mode 0).
- Valid gate g_v, evaluated only when not holding:
  - mode 0: 1
  - mode 1: toggles every cycle; starts 1 after reset
  - mode 2: LFSR bit0
  - mode 3: 0
- m_valid = hold_q | (!tx_empty & g_v). m_payload and m_last are the TX head.
- Hold rule: once m_valid=1 without m_ready, hold_q=1. m_valid, m_payload and m_last stay stable until m_ready; mode changes do not drop valid.
- Transfer on m_valid && m_ready pops TX head and clears hold_q. If m_last, tx_frames increments, wrapping at 2^CNT_W.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, never all-zero.
- Ready gate g_r is registered: the next-state value uses cfg_ready_mode with LFSR bit1, alternate phase, or constant.
- s_ready = g_r_q & !rx_full. s_ready may drop at any time.
- Capture on s_valid && s_ready. If s_last, rx_frames increments. The RX FIFO cannot overflow by construction.
- Captured beat is visible at rx_rd_data the cycle after capture.
- RX pop: rx_rd_en && !rx_empty pops the head. rx_rd_en while empty is ignored; rx_rd_data is don't-care when empty.
- Simultaneous push and pop:
  - Allowed in both FIFOs; level unchanged.
  - At full, a TX push is rejected even if a same-cycle pop occurs (tx_full is evaluated pre-pop).
  - At empty, pop is ignored and the push succeeds.
- FIFO pointers wrap modulo DEPTH; level distinguishes full (=DEPTH) from empty.
- Watchdog:
  - Counts consecutive cycles with (m_valid && !m_ready) or (rx_in_frame && !s_valid).
  - rx_in_frame = a captured beat without last is outstanding.
  - Counter resets on any transfer, either side.
  - Reaching TIMEOUT sets timeout_flag (sticky until reset); the counter saturates.

Decomposition:
- Package stream_bfm_pkg:
  - mode enum: MODE_ALWAYS, MODE_ALT, MODE_RAND, MODE_STALL
  - LFSR_SEED, LFSR_TAPS
- Sub-module sync_fifo (DATA_W+1 wide for the last bit, DEPTH), FWFT, with level/full/empty; instantiated twice (TX, RX).
- Throttle, hold, counter and watchdog logic stay in stream_bfm_v2.

Test Plan:
- Reset then idle, both modes 0 -> m_valid=0, s_ready=1 from 2nd post-reset cycle, rx_empty=1, all counters 0.
- Push 3 beats A,B,C (C last), m_ready=1, mode 0 -> A,B,C on consecutive cycles starting cycle after first push; tx_frames=1.
- Loopback m_*->s_*, valid mode 2 and ready mode 1, 100 frames of 4 beats -> rx_frames=100, RX order equals TX order, no beat lost.
- Hold check: m_ready=0 for 10 cycles with valid mode 1 -> m_valid stays 1 and payload is constant all 10 cycles; pop occurs only on ready.
- Fill TX with DEPTH=16 beats, then push 1 more with simultaneous m_ready pop -> tx_drop=1, tx_level=15 after the DUT pop, extra beat absent.
- TIMEOUT=8, one beat pushed, m_ready=0 -> timeout_flag rises on 8th stalled cycle and remains 1 after m_ready returns; reset clears it.

Source files
------------

// File: rtl/stream_bfm_pkg.sv
// rtl/stream_bfm_pkg.sv - throttle modes, LFSR constants and gate helpers for stream_bfm_v2
package stream_bfm_pkg;

    typedef enum logic [1:0] {
        MODE_ALWAYS = 2'd0,
        MODE_ALT    = 2'd1,
        MODE_RAND   = 2'd2,
        MODE_STALL  = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic gate_sel(input mode_e m, input logic alt, input logic rnd);
        case (m)
            MODE_ALWAYS: return 1'b1;
            MODE_ALT:    return alt;
            MODE_RAND:   return rnd;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy level
module sync_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full is judged on the pre-pop level, so a push at full is refused even with a same-cycle pop
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en & !full;
    assign pop     = rd_en & !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/stream_bfm_v2.sv
// rtl/stream_bfm_v2.sv - throttled valid/ready stream driver and capture with frame counters and watchdog
module stream_bfm_v2 #(
    parameter int DATA_W  = 255,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_wr_en,
    input  logic [DATA_W-1:0]        tx_wr_data,
    input  logic                     tx_wr_last,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [DATA_W-1:0]        m_payload,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    input  logic [DATA_W-1:0]        s_payload,
    input  logic                     rx_rd_en,
    output logic [DATA_W-1:0]        rx_rd_data,
    output logic                     rx_rd_last,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_level,
    input  logic [1:0]               cfg_valid_mode,
    input  logic [1:0]               cfg_ready_mode,
    output logic [CNT_W-1:0]         tx_frames,
    output logic [CNT_W-1:0]         rx_frames,
    output logic                     tx_drop,
    output logic                     timeout_flag
);

    import stream_bfm_pkg::*;

    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [DATA_W:0]  tx_head;
    logic [DATA_W:0]  rx_head;
    logic             tx_full_i;
    logic             tx_empty;
    logic             rx_full;
    logic             rx_empty_i;
    logic [LW-1:0]    tx_level_i;
    logic [LW-1:0]    rx_level_i;

    logic [15:0]      lfsr_q;
    logic             alt_q;
    logic             g_r_q;
    logic             hold_q;
    logic             rx_in_frame_q;
    logic [WD_W-1:0]  wd_cnt_q;

    logic             g_v;
    logic             g_r_next;
    logic             tx_xfer;
    logic             rx_xfer;
    logic             stall;

    sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr_en),
        .wr_data ({tx_wr_last, tx_wr_data}),
        .rd_en   (tx_xfer),
        .rd_data (tx_head),
        .full    (tx_full_i),
        .empty   (tx_empty),
        .level   (tx_level_i)
    );

    sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_xfer),
        .wr_data ({s_last, s_payload}),
        .rd_en   (rx_rd_en),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty_i),
        .level   (rx_level_i)
    );

    assign g_v      = gate_sel(mode_e'(cfg_valid_mode), alt_q, lfsr_q[0]);
    assign g_r_next = gate_sel(mode_e'(cfg_ready_mode), alt_q, lfsr_q[1]);

    // Once valid has been shown without ready, hold_q keeps it up regardless of the gate
    assign m_valid   = !reset & (hold_q | (!tx_empty & g_v));
    assign m_payload = tx_head[DATA_W-1:0];
    assign m_last    = tx_head[DATA_W];
    assign tx_xfer   = m_valid & m_ready;

    assign s_ready    = !reset & g_r_q & !rx_full;
    assign rx_xfer    = s_valid & s_ready;
    assign rx_rd_data = rx_head[DATA_W-1:0];
    assign rx_rd_last = rx_head[DATA_W];

    assign tx_full  = !reset & tx_full_i;
    assign rx_empty = reset | rx_empty_i;
    assign tx_level = reset ? '0 : tx_level_i;
    assign rx_level = reset ? '0 : rx_level_i;

    assign stall = (m_valid & !m_ready) | (rx_in_frame_q & !s_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q        <= LFSR_SEED;
            alt_q         <= 1'b1;
            g_r_q         <= 1'b0;
            hold_q        <= 1'b0;
            rx_in_frame_q <= 1'b0;
            wd_cnt_q      <= '0;
            tx_frames     <= '0;
            rx_frames     <= '0;
            tx_drop       <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            alt_q  <= !alt_q;
            g_r_q  <= g_r_next;
            hold_q <= m_valid & !m_ready;

            if (tx_wr_en && tx_full_i) begin
                tx_drop <= 1'b1;
            end
            if (tx_xfer && m_last) begin
                tx_frames <= tx_frames + CNT_W'(1);
            end
            if (rx_xfer) begin
                rx_in_frame_q <= !s_last;
                if (s_last) begin
                    rx_frames <= rx_frames + CNT_W'(1);
                end
            end

            // Watchdog counts only unbroken stall runs and saturates at TIMEOUT
            if (tx_xfer || rx_xfer || !stall) begin
                wd_cnt_q <= '0;
            end else begin
                if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                    wd_cnt_q <= wd_cnt_q + WD_W'(1);
                end
                if (wd_cnt_q >= WD_W'(TIMEOUT - 1)) begin
                    timeout_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_bfm_v2.sv
// tb/tb_stream_bfm_v2.sv - directed self-checking bench for stream_bfm_v2
module tb_stream_bfm_v2;

    localparam int DATA_W = 255;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int NBEATS = 400;

    logic              clk;
    logic              reset;
    logic              tx_wr_en;
    logic [DATA_W-1:0] tx_wr_data;
    logic              tx_wr_last;
    logic              tx_full;
    logic [4:0]        tx_level;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [DATA_W-1:0] m_payload;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [DATA_W-1:0] s_payload;
    logic              rx_rd_en;
    logic [DATA_W-1:0] rx_rd_data;
    logic              rx_rd_last;
    logic              rx_empty;
    logic [4:0]        rx_level;
    logic [1:0]        cfg_valid_mode;
    logic [1:0]        cfg_ready_mode;
    logic [CNT_W-1:0]  tx_frames;
    logic [CNT_W-1:0]  rx_frames;
    logic              tx_drop;
    logic              timeout_flag;

    logic              loop;
    logic              mr_drv;
    logic              sv_drv;
    logic              sl_drv;
    logic [DATA_W-1:0] sp_drv;

    int n_vec;
    int n_err;

    assign m_ready   = loop ? s_ready   : mr_drv;
    assign s_valid   = loop ? m_valid   : sv_drv;
    assign s_last    = loop ? m_last    : sl_drv;
    assign s_payload = loop ? m_payload : sp_drv;

    stream_bfm_v2 #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_wr_en       (tx_wr_en),
        .tx_wr_data     (tx_wr_data),
        .tx_wr_last     (tx_wr_last),
        .tx_full        (tx_full),
        .tx_level       (tx_level),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .m_payload      (m_payload),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .s_payload      (s_payload),
        .rx_rd_en       (rx_rd_en),
        .rx_rd_data     (rx_rd_data),
        .rx_rd_last     (rx_rd_last),
        .rx_empty       (rx_empty),
        .rx_level       (rx_level),
        .cfg_valid_mode (cfg_valid_mode),
        .cfg_ready_mode (cfg_ready_mode),
        .tx_frames      (tx_frames),
        .rx_frames      (rx_frames),
        .tx_drop        (tx_drop),
        .timeout_flag   (timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] beat(input int i);
        logic [255:0] t;
        t = {8{32'(i) ^ 32'h5A5A_0000}};
        return t[DATA_W-1:0];
    endfunction

    initial begin
        int sent;
        int rcvd;
        int cyc;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        tx_wr_en = 1'b0; tx_wr_data = '0; tx_wr_last = 1'b0;
        rx_rd_en = 1'b0;
        cfg_valid_mode = 2'd0; cfg_ready_mode = 2'd0;
        loop = 1'b0; mr_drv = 1'b0; sv_drv = 1'b0; sl_drv = 1'b0; sp_drv = '0;

        // reset and idle
        step(); step();
        chk("rst_m_valid", 256'(m_valid), 256'(1'b0));
        chk("rst_s_ready", 256'(s_ready), 256'(1'b0));
        chk("rst_tx_full", 256'(tx_full), 256'(1'b0));
        chk("rst_rx_empty", 256'(rx_empty), 256'(1'b1));
        chk("rst_tx_level", 256'(tx_level), 256'(0));
        chk("rst_rx_level", 256'(rx_level), 256'(0));
        reset = 1'b0;
        #1;
        chk("post1_s_ready", 256'(s_ready), 256'(1'b0));
        chk("post1_m_valid", 256'(m_valid), 256'(1'b0));
        step();
        chk("post2_s_ready", 256'(s_ready), 256'(1'b1));
        chk("post2_m_valid", 256'(m_valid), 256'(1'b0));
        chk("idle_rx_empty", 256'(rx_empty), 256'(1'b1));
        chk("idle_tx_frames", 256'(tx_frames), 256'(0));
        chk("idle_rx_frames", 256'(rx_frames), 256'(0));
        chk("idle_tx_drop", 256'(tx_drop), 256'(1'b0));
        chk("idle_timeout", 256'(timeout_flag), 256'(1'b0));

        // single capture, visible the cycle after, then pop and pop-on-empty
        sv_drv = 1'b1; sl_drv = 1'b1; sp_drv = beat(77);
        step();
        sv_drv = 1'b0;
        chk("cap_rx_empty", 256'(rx_empty), 256'(1'b0));
        chk("cap_data", 256'(rx_rd_data), 256'(beat(77)));
        chk("cap_last", 256'(rx_rd_last), 256'(1'b1));
        chk("cap_rx_frames", 256'(rx_frames), 256'(1));
        rx_rd_en = 1'b1;
        step();
        chk("pop_rx_empty", 256'(rx_empty), 256'(1'b1));
        step();
        chk("pop_empty_level", 256'(rx_level), 256'(0));
        rx_rd_en = 1'b0;

        // A,B,C back to back, C last
        mr_drv = 1'b1;
        tx_wr_en = 1'b1; tx_wr_data = beat(1); tx_wr_last = 1'b0;
        step();
        tx_wr_data = beat(2);
        chk("abc_a_valid", 256'(m_valid), 256'(1'b1));
        chk("abc_a_data", 256'(m_payload), 256'(beat(1)));
        chk("abc_a_last", 256'(m_last), 256'(1'b0));
        step();
        tx_wr_data = beat(3); tx_wr_last = 1'b1;
        chk("abc_b_data", 256'(m_payload), 256'(beat(2)));
        step();
        tx_wr_en = 1'b0; tx_wr_last = 1'b0;
        chk("abc_c_data", 256'(m_payload), 256'(beat(3)));
        chk("abc_c_last", 256'(m_last), 256'(1'b1));
        step();
        chk("abc_done_valid", 256'(m_valid), 256'(1'b0));
        chk("abc_tx_frames", 256'(tx_frames), 256'(1));

        // hold under back-pressure, with a mode change mid-hold
        mr_drv = 1'b0; cfg_valid_mode = 2'd1;
        tx_wr_en = 1'b1; tx_wr_data = beat(4); tx_wr_last = 1'b1;
        step();
        tx_wr_en = 1'b0; tx_wr_last = 1'b0;
        for (int i = 0; i < 4 && !m_valid; i++) step();
        chk("hold_rise", 256'(m_valid), 256'(1'b1));
        for (int i = 0; i < 10; i++) begin
            if (i == 5) cfg_valid_mode = 2'd3;
            step();
            chk("hold_valid", 256'(m_valid), 256'(1'b1));
            chk("hold_data", 256'(m_payload), 256'(beat(4)));
            chk("hold_level", 256'(tx_level), 256'(1));
        end
        mr_drv = 1'b1;
        step();
        mr_drv = 1'b0;
        chk("hold_release_valid", 256'(m_valid), 256'(1'b0));
        chk("hold_release_level", 256'(tx_level), 256'(0));
        chk("hold_tx_frames", 256'(tx_frames), 256'(2));

        // loopback, random valid and alternating ready
        cfg_valid_mode = 2'd2; cfg_ready_mode = 2'd1; loop = 1'b1;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < NBEATS && cyc < 10000) begin
            tx_wr_en   = (sent < NBEATS) && !tx_full;
            tx_wr_data = beat(sent + 100);
            tx_wr_last = (sent % 4 == 3);
            rx_rd_en   = !rx_empty;
            if (!rx_empty) begin
                chk("lb_data", 256'(rx_rd_data), 256'(beat(rcvd + 100)));
                chk("lb_last", 256'(rx_rd_last), 256'(rcvd % 4 == 3));
            end
            step();
            if (tx_wr_en) sent++;
            if (rx_rd_en) rcvd++;
            cyc++;
        end
        tx_wr_en = 1'b0; tx_wr_last = 1'b0; rx_rd_en = 1'b0;
        loop = 1'b0; cfg_valid_mode = 2'd0; cfg_ready_mode = 2'd0;
        chk("lb_count", 256'(rcvd), 256'(NBEATS));
        chk("lb_rx_frames", 256'(rx_frames), 256'(101));
        chk("lb_tx_frames", 256'(tx_frames), 256'(102));
        chk("lb_tx_level", 256'(tx_level), 256'(0));
        chk("lb_rx_level", 256'(rx_level), 256'(0));
        chk("lb_tx_drop", 256'(tx_drop), 256'(1'b0));

        // fill TX, then push at full with a same-cycle pop
        cfg_valid_mode = 2'd3;
        for (int k = 0; k < DEPTH; k++) begin
            tx_wr_en = 1'b1; tx_wr_data = beat(1000 + k); tx_wr_last = (k == DEPTH - 1);
            step();
        end
        tx_wr_last = 1'b0;
        chk("fill_full", 256'(tx_full), 256'(1'b1));
        chk("fill_level", 256'(tx_level), 256'(DEPTH));
        chk("fill_valid", 256'(m_valid), 256'(1'b0));
        tx_wr_data = beat(9999); cfg_valid_mode = 2'd0; mr_drv = 1'b1;
        step();
        tx_wr_en = 1'b0;
        chk("drop_flag", 256'(tx_drop), 256'(1'b1));
        chk("drop_level", 256'(tx_level), 256'(DEPTH - 1));
        for (int k = 1; k < DEPTH; k++) begin
            chk("drain_data", 256'(m_payload), 256'(beat(1000 + k)));
            step();
        end
        mr_drv = 1'b0;
        chk("drain_valid", 256'(m_valid), 256'(1'b0));
        chk("drain_level", 256'(tx_level), 256'(0));
        chk("drain_tx_frames", 256'(tx_frames), 256'(103));

        // watchdog at TIMEOUT=8, then reset with beats buffered
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("wd_clear", 256'(timeout_flag), 256'(1'b0));
        chk("wd_tx_frames", 256'(tx_frames), 256'(0));
        tx_wr_en = 1'b1; tx_wr_data = beat(5);
        step();
        tx_wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("wd_early", 256'(timeout_flag), 256'(1'b0));
        end
        step();
        chk("wd_rise", 256'(timeout_flag), 256'(1'b1));
        mr_drv = 1'b1;
        step();
        mr_drv = 1'b0;
        chk("wd_sticky", 256'(timeout_flag), 256'(1'b1));
        chk("wd_popped", 256'(m_valid), 256'(1'b0));
        tx_wr_en = 1'b1; tx_wr_data = beat(6);
        step();
        tx_wr_data = beat(7);
        step();
        tx_wr_en = 1'b0;
        chk("mid_level", 256'(tx_level), 256'(2));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 256'(m_valid), 256'(1'b0));
        chk("mid_rst_level", 256'(tx_level), 256'(0));
        step();
        chk("mid_rst_timeout", 256'(timeout_flag), 256'(1'b0));
        reset = 1'b0;
        step(); step();
        chk("mid_after_valid", 256'(m_valid), 256'(1'b0));
        chk("mid_after_level", 256'(tx_level), 256'(0));
        chk("mid_after_frames", 256'(tx_frames), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
